// File: rtl/edge_det_pkg.sv
// +----------------------------------------------------------------------+
// | edge_det_pkg : shared types and defaults for edge_detect_multi        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  localparam int unsigned DEF_CH          = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_LEN    = 8;
  localparam logic        DEF_IDLE_LEVEL  = 1'b1;

  // Returns {rise_enable, fall_enable} for a mode.
  function automatic logic [1:0] mode_mask(input edge_mode_t m);
    case (m)
      EDGE_FALL: return 2'b01;
      EDGE_RISE: return 2'b10;
      EDGE_BOTH: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_det_chan.sv
// +----------------------------------------------------------------------+
// | edge_det_chan : one channel - sync chain, glitch filter, rise/fall    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module edge_det_chan #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 8,
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_d_o,
  output logic fall_d_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned      CNT_W    = $clog2(FILT_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q, rise_d, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Input held its new level long enough: accept it.
      level_d = sync_out;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o  = level_q;
  assign rise_d_o = rise_d;
  assign fall_d_o = fall_d;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

`default_nettype wire

// File: rtl/edge_detect_multi.sv
// +----------------------------------------------------------------------+
// | edge_detect_multi : multi-channel input conditioner / edge detector   |
// | Optional sticky flags with EDGE_DET_STICKY_EN.           Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module edge_detect_multi
  import edge_det_pkg::*;
#(
  parameter int unsigned CH          = DEF_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter logic        IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  input  logic [1:0]    mode,
  output logic [CH-1:0] level_q,
  output logic [CH-1:0] edge_pulse,
  output logic [CH-1:0] rise_pulse,
  output logic [CH-1:0] fall_pulse,
  output logic          any_edge
`ifdef EDGE_DET_STICKY_EN
  ,
  input  logic [CH-1:0] sticky_clr,
  output logic [CH-1:0] sticky_q
`endif
);

  edge_mode_t    mode_q;
  logic [1:0]    mask;
  logic [CH-1:0] rise_d, fall_d, edge_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .din_i    (din[i]),
      .level_o  (level_q[i]),
      .rise_d_o (rise_d[i]),
      .fall_d_o (fall_d[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i])
    );
  end

  // Masking uses the mode captured on the previous edge.
  always_comb begin
    mask   = mode_mask(mode_q);
    edge_d = (rise_d & {CH{mask[1]}}) | (fall_d & {CH{mask[0]}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= EDGE_FALL;
      edge_pulse <= '0;
      any_edge   <= 1'b0;
    end else begin
      mode_q     <= edge_mode_t'(mode);
      edge_pulse <= edge_d;
      any_edge   <= |edge_d;
    end
  end

`ifdef EDGE_DET_STICKY_EN
  // A new pulse takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~sticky_clr) | edge_pulse;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
// +----------------------------------------------------------------------+
// | tb_edge_detect_multi : directed self-checking bench for the detector  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [1:0] mode;
  logic [3:0] level_q, edge_pulse, rise_pulse, fall_pulse;
  logic       any_edge;
`ifdef EDGE_DET_STICKY_EN
  logic [3:0] sticky_clr;
  logic [3:0] sticky_q;
`endif

  always #5 clk = ~clk;

  edge_detect_multi #(
    .CH          (4),
    .SYNC_STAGES (2),
    .FILT_LEN    (8),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .mode       (mode),
    .level_q    (level_q),
    .edge_pulse (edge_pulse),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_edge   (any_edge)
`ifdef EDGE_DET_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_q   (sticky_q)
`endif
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] edg;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the expected outputs, advance one edge, then compare.
  task automatic cyc(input logic [3:0] lvl, input logic [3:0] rise,
                     input logic [3:0] fall, input logic [3:0] edg);
    exp_t e;
    sb.push_back('{lvl: lvl, rise: rise, fall: fall, edg: edg, any: |edg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("level_q",    32'(level_q),    32'(e.lvl));
    check("rise_pulse", 32'(rise_pulse), 32'(e.rise));
    check("fall_pulse", 32'(fall_pulse), 32'(e.fall));
    check("edge_pulse", 32'(edge_pulse), 32'(e.edg));
    check("any_edge",   32'(any_edge),   32'(e.any));
  endtask

  task automatic quiet(input int n, input logic [3:0] lvl);
    for (int k = 0; k < n; k++) cyc(lvl, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    rst  = 1'b1;
    din  = 4'hF;
    mode = 2'b00;
`ifdef EDGE_DET_STICKY_EN
    sticky_clr = 4'h0;
`endif
    // Reset defaults, then idle input for 20 cycles.
    cyc(4'hF, 4'h0, 4'h0, 4'h0);
    cyc(4'hF, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    quiet(20, 4'hF);

    // Falling latency on ch0: event at edge 9.
    din = 4'hE;
    quiet(9, 4'hF);
    cyc(4'hE, 4'h0, 4'h1, 4'h1);
    quiet(3, 4'hE);

    // 7-cycle glitch on ch2 is rejected.
    din = 4'hA;
    quiet(7, 4'hE);
    din = 4'hE;
    quiet(10, 4'hE);

    // 8-cycle low on ch2 gives one fall, then the return rise.
    din = 4'hA;
    quiet(8, 4'hE);
    din = 4'hE;
    quiet(1, 4'hE);
    cyc(4'hA, 4'h0, 4'h4, 4'h4);
    quiet(7, 4'hA);
    cyc(4'hE, 4'h4, 4'h0, 4'h0);
    quiet(2, 4'hE);

    // Mode 01: only the rise on ch1 reaches edge_pulse.
    mode = 2'b01;
    din  = 4'hC;
    quiet(9, 4'hE);
    cyc(4'hC, 4'h0, 4'h2, 4'h0);
    din = 4'hE;
    quiet(9, 4'hC);
    cyc(4'hE, 4'h2, 4'h0, 4'h2);
    quiet(2, 4'hE);

    // Mode 11: level tracks, edge_pulse and any_edge stay low.
    mode = 2'b11;
    din  = 4'hC;
    quiet(9, 4'hE);
    cyc(4'hC, 4'h0, 4'h2, 4'h0);
    din = 4'hE;
    quiet(9, 4'hC);
    cyc(4'hE, 4'h2, 4'h0, 4'h0);
    quiet(2, 4'hE);

    // Mode 10: rise on ch0, then falls on all channels together.
    mode = 2'b10;
    din  = 4'hF;
    quiet(9, 4'hE);
    cyc(4'hF, 4'h1, 4'h0, 4'h1);
    din = 4'h0;
    quiet(9, 4'hF);
    cyc(4'h0, 4'h0, 4'hF, 4'hF);
    quiet(2, 4'h0);

    // Reset while the filter count is at 5.
    din = 4'hF;
    quiet(7, 4'h0);
    check("cnt_before_rst", 32'(dut.g_chan[0].u_chan.cnt_q), 32'd5);
    rst = 1'b1;
    cyc(4'hF, 4'h0, 4'h0, 4'h0);
    check("cnt_after_rst", 32'(dut.g_chan[0].u_chan.cnt_q), 32'd0);
    rst = 1'b0;
    quiet(12, 4'hF);

`ifdef EDGE_DET_STICKY_EN
    check("sticky_reset", 32'(sticky_q), 32'h0);
    din = 4'h7;
    quiet(8, 4'hF);
    sticky_clr = 4'h8;
    quiet(1, 4'hF);
    cyc(4'h7, 4'h0, 4'h8, 4'h8);
    cyc(4'h7, 4'h0, 4'h0, 4'h0);
    check("sticky_set_wins", 32'(sticky_q), 32'h8);
    sticky_clr = 4'h0;
    cyc(4'h7, 4'h0, 4'h0, 4'h0);
    check("sticky_hold", 32'(sticky_q), 32'h8);
    sticky_clr = 4'h8;
    cyc(4'h7, 4'h0, 4'h0, 4'h0);
    check("sticky_clear", 32'(sticky_q), 32'h0);
    sticky_clr = 4'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel input conditioner and edge detector. Each channel synchronises an asynchronous pin, such as a UART RX line, into the `clk` domain and rejects glitches shorter than a programmable length. It emits single-cycle edge pulses selected by a run-time mode. It sits between the pad inputs and the serial receivers and timers, and supersedes the single-channel fixed falling-edge detector.

## Interface
Parameters:
- `CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILT_LEN`, 8: consecutive stable cycles required to accept a new level (≥1; 1 = filter bypassed).
- `IDLE_LEVEL`, 1'b1: reset value of the synchroniser and filtered level (UART idle high).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  CH  asynchronous channel inputs.
- `mode`  in  2  edge select, common to all channels: 00 falling, 01 rising, 10 both, 11 pulses disabled.
- `level_q`  out  CH  filtered, synchronised level per channel.
- `edge_pulse`  out  CH  one-cycle pulse on a selected edge.
- `rise_pulse`  out  CH  one-cycle pulse on a rising edge of `level_q`, independent of `mode`.
- `fall_pulse`  out  CH  one-cycle pulse on a falling edge of `level_q`, independent of `mode`.
- `any_edge`  out  1  OR of `edge_pulse`, registered in the same cycle.
- `sticky_clr`  in  CH  present only with `EDGE_DET_STICKY_EN`.
- `sticky_q`  out  CH  present only with `EDGE_DET_STICKY_EN`.

## Operation
- Per channel, the pipeline is: sync chain (SYNC_STAGES flops) → filter counter → `level_q` register → pulse registers.
- Filter behaviour:
  - The counter (width clog2(FILT_LEN)+1) increments each cycle the sync output ≠ `level_q`.
  - It clears to 0 whenever the two are equal.
  - When the count reaches FILT_LEN-1 while they still differ, `level_q` takes the sync output on the next edge and the counter clears.
  - Inputs that toggle faster than FILT_LEN cycles never change `level_q`.
- Edge pulses:
  - `rise_pulse` and `fall_pulse` are registered and assert in the same cycle `level_q` shows its new value.
  - `edge_pulse` equals `rise_pulse` and/or `fall_pulse`, gated by the `mode` value registered on the previous edge.
- Mode behaviour:
  - A `mode` change alters only masking. It never changes `level_q`, the counters, or `rise_pulse`/`fall_pulse`.
  - In mode 11, `level_q` keeps tracking the input, so re-enabling does not produce stale pulses.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.
- Reset values (assert `rst` for ≥1 edge):
  - Sync flops and `level_q` = IDLE_LEVEL.
  - Counters = 0.
  - All pulse outputs, `any_edge` and `sticky_q` = 0.
  - Registered mode = 00.
- Reset asserted mid-filter discards partial counts.
- If `din` ≠ IDLE_LEVEL when reset releases, the corresponding edge is reported after normal latency. This is intended: a line held low is treated as a start bit.

## Timing
- Latency: `din` changes before edge 0 and stays stable; `level_q` and the pulses update at edge SYNC_STAGES+FILT_LEN-1 (0-based).
  - With defaults, that is edge 9.
  - With FILT_LEN=1, it is edge SYNC_STAGES.
- Pulse width is exactly 1 cycle. The minimum spacing between pulses on a channel is FILT_LEN cycles.
- `mode` to masking effect: 1 cycle.
- `any_edge` is coincident with `edge_pulse`.

## Configuration
- `EDGE_DET_STICKY_EN` defined:
  - Adds the `sticky_clr` and `sticky_q` ports.
  - `sticky_q[i]` sets on `edge_pulse[i]` and clears on `sticky_clr[i]`.
  - Set wins on a simultaneous set and clear; `sticky_q` stays 1.
- Not defined: the ports and flags are absent, and all other behaviour is identical.

## Structure
- Shared package `edge_det_pkg`:
  - `edge_mode_t` enum (`EDGE_FALL`=2'b00, `EDGE_RISE`=2'b01, `EDGE_BOTH`=2'b10, `EDGE_OFF`=2'b11).
  - Default parameter constants.
- Sub-module `edge_det_chan`: one channel (sync chain, filter, `level_q`, rise/fall regs), instantiated CH times via generate.
- The top level holds the mode register, masking, `any_edge` and the sticky logic.

## Test plan
- Reset defaults: CH=4, reset with `din`=4'hF, then hold for 20 cycles → `level_q`=4'hF and no pulses at any time.
- Falling latency: `din[0]` 1→0 before edge 0, mode 00 → `fall_pulse[0]` and `edge_pulse[0]` high only at edge 9, and `level_q[0]`=0 from edge 9.
- Glitch rejection: a 7-cycle low glitch on `din[2]` (FILT_LEN=8) → no pulse and `level_q[2]` stays 1. An 8-cycle low produces exactly one fall pulse.
- Mode masking: mode 01 with a falling then rising edge on ch1 → `edge_pulse[1]` only on the rise, `fall_pulse[1]` still fires. Mode 11 → `edge_pulse`=0 and `any_edge`=0.
- Simultaneous events and mid-filter reset: falling edges on all channels in the same cycle, mode 10 → `edge_pulse`=4'hF for one cycle. Reset asserted at count 5 → no pulse, counter 0, `level_q`=IDLE_LEVEL.
- Sticky (macro on): an edge on ch3 while `sticky_clr[3]`=1 in the pulse cycle → `sticky_q[3]`=1. A later clear alone → 0 on the next edge.
